// File: rtl/tow_match_keeper.sv
// tow_match_keeper
//
// Match-level scorekeeper for Tug of War. Sits downstream of the two
// per-player playfield score blocks, counts games won per side, shows both
// tallies on seven-segment displays, holds the playfield in reset for a
// short pause after every game and declares a match winner.
//
// Parameters
//   GAMES_TO_WIN  games needed to win the match (1..9)
//   PAUSE_CYCLES  cycles round_reset is held after each game (>=1)
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   win_l/win_r  playfield win flags; may be held high, counted on rising edge
//   round_reset  registered reset to the playfield score blocks
//   hex_l/hex_r  active-low segments {g,f,e,d,c,b,a} of each side's count
//   game_over    registered, match decided
//   winner       registered, 00 none, 10 left, 01 right
//
// Optional feature
//   TOW_MATCH_AUTORESTART_EN  when defined, DONE lasts 8*PAUSE_CYCLES cycles
//   and then the match restarts from zero on its own. When undefined, DONE
//   holds until reset and no restart counter exists.
//
// There is no valid/ready handshake on this block: win inputs are level
// flags whose rising edges are events, and all outputs are plain levels.
//
// The FSM state is held in the signal "state" (type state_t) for
// observation by checkers.

module tow_match_keeper #(
  parameter int GAMES_TO_WIN = 7,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win_l,
  input  logic       win_r,
  output logic       round_reset,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int PW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_CYCLES);
  localparam logic [PW-1:0] PAUSE_ONE  = PW'(1);
  localparam logic [3:0]    TARGET     = 4'(GAMES_TO_WIN);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    PLAY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pause_cnt, pause_cnt_n;
  logic [3:0]    cnt_l, cnt_l_n;
  logic [3:0]    cnt_r, cnt_r_n;
  logic          round_reset_n;
  logic          game_over_n;
  logic [1:0]    winner_n;
  logic          win_l_q, win_r_q;
  logic          ev_l, ev_r;

`ifdef TOW_MATCH_AUTORESTART_EN
  localparam int RW = $clog2(8 * PAUSE_CYCLES + 1);
  localparam logic [RW-1:0] RESTART_LOAD = RW'(8 * PAUSE_CYCLES);
  localparam logic [RW-1:0] RESTART_ONE  = RW'(1);
  logic [RW-1:0] restart_cnt, restart_cnt_n;
`endif

  // Rising-edge game events; a held win produces a single event.
  assign ev_l = win_l & ~win_l_q;
  assign ev_r = win_r & ~win_r_q;

  always_comb begin
    state_n       = state;
    pause_cnt_n   = pause_cnt;
    cnt_l_n       = cnt_l;
    cnt_r_n       = cnt_r;
    round_reset_n = round_reset;
    game_over_n   = game_over;
    winner_n      = winner;
`ifdef TOW_MATCH_AUTORESTART_EN
    restart_cnt_n = restart_cnt;
`endif
    case (state)
      PAUSE: begin
        round_reset_n = 1'b1;
        // pause_cnt counts the remaining high cycles including this one,
        // so leaving on the value 1 gives exactly PAUSE_CYCLES cycles.
        if (pause_cnt <= PAUSE_ONE) begin
          state_n       = PLAY;
          round_reset_n = 1'b0;
        end else begin
          pause_cnt_n = pause_cnt - PAUSE_ONE;
        end
      end

      PLAY: begin
        round_reset_n = 1'b0;
        if (ev_l && ev_r) begin
          // Draw: no score change, just another pause.
          state_n       = PAUSE;
          pause_cnt_n   = PAUSE_LOAD;
          round_reset_n = 1'b1;
        end else if (ev_l) begin
          cnt_l_n       = cnt_l + 4'd1;
          round_reset_n = 1'b1;
          if (cnt_l_n == TARGET) begin
            state_n     = DONE;
            game_over_n = 1'b1;
            winner_n    = 2'b10;
`ifdef TOW_MATCH_AUTORESTART_EN
            restart_cnt_n = RESTART_LOAD;
`endif
          end else begin
            state_n     = PAUSE;
            pause_cnt_n = PAUSE_LOAD;
          end
        end else if (ev_r) begin
          cnt_r_n       = cnt_r + 4'd1;
          round_reset_n = 1'b1;
          if (cnt_r_n == TARGET) begin
            state_n     = DONE;
            game_over_n = 1'b1;
            winner_n    = 2'b01;
`ifdef TOW_MATCH_AUTORESTART_EN
            restart_cnt_n = RESTART_LOAD;
`endif
          end else begin
            state_n     = PAUSE;
            pause_cnt_n = PAUSE_LOAD;
          end
        end
      end

      DONE: begin
        round_reset_n = 1'b1;
        game_over_n   = 1'b1;
`ifdef TOW_MATCH_AUTORESTART_EN
        // Same "count includes this cycle" scheme as the pause counter.
        if (restart_cnt <= RESTART_ONE) begin
          state_n     = PAUSE;
          pause_cnt_n = PAUSE_LOAD;
          cnt_l_n     = 4'd0;
          cnt_r_n     = 4'd0;
          winner_n    = 2'b00;
          game_over_n = 1'b0;
        end else begin
          restart_cnt_n = restart_cnt - RESTART_ONE;
        end
`endif
      end

      default: begin
        state_n       = PAUSE;
        pause_cnt_n   = PAUSE_LOAD;
        round_reset_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PAUSE;
      pause_cnt   <= PAUSE_LOAD;
      cnt_l       <= 4'd0;
      cnt_r       <= 4'd0;
      round_reset <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 2'b00;
      win_l_q     <= 1'b0;
      win_r_q     <= 1'b0;
`ifdef TOW_MATCH_AUTORESTART_EN
      restart_cnt <= '0;
`endif
    end else begin
      state       <= state_n;
      pause_cnt   <= pause_cnt_n;
      cnt_l       <= cnt_l_n;
      cnt_r       <= cnt_r_n;
      round_reset <= round_reset_n;
      game_over   <= game_over_n;
      winner      <= winner_n;
      // Edge registers track inputs in every state, so a win raised
      // during a pause cannot register as an edge once play resumes.
      win_l_q     <= win_l;
      win_r_q     <= win_r;
`ifdef TOW_MATCH_AUTORESTART_EN
      restart_cnt <= restart_cnt_n;
`endif
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (value)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign hex_l = seg_decode(cnt_l);
  assign hex_r = seg_decode(cnt_r);

endmodule

// File: tb/tb_tow_match_keeper.sv
// Testbench for tow_match_keeper with GAMES_TO_WIN = 3, PAUSE_CYCLES = 4.
// A table of per-cycle {inputs, expected outputs} records covers reset,
// pause timing, single games, draws, held wins and the match win; a
// hand-written tail covers the DONE hold (or autorestart) and a re-reset.

module tb_tow_match_keeper;

  localparam logic [6:0] H0 = 7'b1000000;
  localparam logic [6:0] H1 = 7'b1111001;
  localparam logic [6:0] H2 = 7'b0100100;
  localparam logic [6:0] H3 = 7'b0110000;

  logic       clk;
  logic       reset;
  logic       win_l;
  logic       win_r;
  logic       round_reset;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic       game_over;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  tow_match_keeper #(
    .GAMES_TO_WIN(3),
    .PAUSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .win_l(win_l),
    .win_r(win_r),
    .round_reset(round_reset),
    .hex_l(hex_l),
    .hex_r(hex_r),
    .game_over(game_over),
    .winner(winner)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       wl;
    logic       wr;
    logic       rr;
    logic [6:0] hl;
    logic [6:0] hr;
    logic       go;
    logic [1:0] wn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic wl, input logic wr,
                     input logic rr, input logic [6:0] hl, input logic [6:0] hr,
                     input logic go, input logic [1:0] wn);
    vec_t v;
    v.rst = rst; v.wl = wl; v.wr = wr;
    v.rr = rr; v.hl = hl; v.hr = hr; v.go = go; v.wn = wn;
    vecs.push_back(v);
  endtask

  // Driver: change inputs on the falling edge, sample 1 ns after rising edge.
  task automatic step(input logic rst, input logic wl, input logic wr);
    @(negedge clk);
    reset = rst;
    win_l = wl;
    win_r = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rr, input logic [6:0] hl,
                         input logic [6:0] hr, input logic go, input logic [1:0] wn);
    chk({tag, " round_reset"}, {6'd0, round_reset}, {6'd0, rr});
    chk({tag, " hex_l"}, hex_l, hl);
    chk({tag, " hex_r"}, hex_r, hr);
    chk({tag, " game_over"}, {6'd0, game_over}, {6'd0, go});
    chk({tag, " winner"}, {5'd0, winner}, {5'd0, wn});
  endtask

  initial begin
    logic       e_rr, e_go;
    logic [6:0] e_hl, e_hr;
    logic [1:0] e_wn;

    reset = 1'b1;
    win_l = 1'b0;
    win_r = 1'b0;

    //   rst wl wr | rr hex_l hex_r go winner
    // Reset held two cycles, then four pause cycles, then PLAY.
    add(1, 0, 0,  1, H0, H0, 0, 2'b00);  // 0
    add(1, 0, 0,  1, H0, H0, 0, 2'b00);  // 1
    add(0, 0, 0,  1, H0, H0, 0, 2'b00);  // 2
    add(0, 0, 0,  1, H0, H0, 0, 2'b00);  // 3
    add(0, 0, 0,  1, H0, H0, 0, 2'b00);  // 4
    add(0, 0, 0,  0, H0, H0, 0, 2'b00);  // 5 PLAY
    // Single left game; right pulse in the pause is ignored.
    add(0, 1, 0,  1, H1, H0, 0, 2'b00);  // 6
    add(0, 0, 0,  1, H1, H0, 0, 2'b00);  // 7
    add(0, 0, 1,  1, H1, H0, 0, 2'b00);  // 8
    add(0, 0, 0,  1, H1, H0, 0, 2'b00);  // 9
    add(0, 0, 0,  0, H1, H0, 0, 2'b00);  // 10 PLAY
    // Draw: both rise together.
    add(0, 1, 1,  1, H1, H0, 0, 2'b00);  // 11
    add(0, 0, 0,  1, H1, H0, 0, 2'b00);  // 12
    add(0, 0, 0,  1, H1, H0, 0, 2'b00);  // 13
    add(0, 0, 0,  1, H1, H0, 0, 2'b00);  // 14
    add(0, 0, 0,  0, H1, H0, 0, 2'b00);  // 15 PLAY
    // Left win held six cycles counts once.
    add(0, 1, 0,  1, H2, H0, 0, 2'b00);  // 16
    add(0, 1, 0,  1, H2, H0, 0, 2'b00);  // 17
    add(0, 1, 0,  1, H2, H0, 0, 2'b00);  // 18
    add(0, 1, 0,  1, H2, H0, 0, 2'b00);  // 19
    add(0, 1, 0,  0, H2, H0, 0, 2'b00);  // 20 PLAY, still held
    add(0, 1, 0,  0, H2, H0, 0, 2'b00);  // 21
    add(0, 0, 0,  0, H2, H0, 0, 2'b00);  // 22
    // Right game, then a win rising in the pause held into PLAY.
    add(0, 0, 1,  1, H2, H1, 0, 2'b00);  // 23
    add(0, 0, 0,  1, H2, H1, 0, 2'b00);  // 24
    add(0, 0, 1,  1, H2, H1, 0, 2'b00);  // 25
    add(0, 0, 1,  1, H2, H1, 0, 2'b00);  // 26
    add(0, 0, 1,  0, H2, H1, 0, 2'b00);  // 27 PLAY
    add(0, 0, 1,  0, H2, H1, 0, 2'b00);  // 28 not counted
    add(0, 0, 0,  0, H2, H1, 0, 2'b00);  // 29
    // Third left game wins the match.
    add(0, 1, 0,  1, H3, H1, 1, 2'b10);  // 30
    add(0, 0, 0,  1, H3, H1, 1, 2'b10);  // 31
    add(0, 0, 1,  1, H3, H1, 1, 2'b10);  // 32 ignored in DONE
    add(0, 0, 0,  1, H3, H1, 1, 2'b10);  // 33

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wl, vecs[i].wr);
      chk_all($sformatf("vec%0d", i), vecs[i].rr, vecs[i].hl, vecs[i].hr,
              vecs[i].go, vecs[i].wn);
    end

    // DONE tail: k cycles after the winning edge (vector 30 is k = 0).
    for (int k = 4; k <= 40; k++) begin
      step(1'b0, (k < 30) && (k % 3 == 0), (k < 30) && (k % 4 == 0));
`ifdef TOW_MATCH_AUTORESTART_EN
      e_go = (k < 32);
      e_hl = (k < 32) ? H3 : H0;
      e_hr = (k < 32) ? H1 : H0;
      e_wn = (k < 32) ? 2'b10 : 2'b00;
      e_rr = (k < 36);
`else
      e_go = 1'b1;
      e_hl = H3;
      e_hr = H1;
      e_wn = 2'b10;
      e_rr = 1'b1;
`endif
      chk_all($sformatf("done+%0d", k), e_rr, e_hl, e_hr, e_go, e_wn);
    end

    // Reset restores the reset state, then the pause runs again.
    step(1'b1, 1'b0, 1'b0);
    chk_all("rereset", 1'b1, H0, H0, 1'b0, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_all($sformatf("repause%0d", k), (k < 4), H0, H0, 1'b0, 2'b00);
    end
    step(1'b0, 1'b0, 1'b1);
    chk_all("postreset right game", 1'b1, H0, H1, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
